// File: rtl/uart_async_transmitter.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each held CLKS_PER_BIT clocks.
// TxD/TxD_busy are flops that change on the accepting edge; a request held through the stop bit chains frames gap-free.
module uart_async_transmitter #(
   parameter int CLK_FREQ     = 10_000_000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       TxD_start,
   input  logic [7:0] TxD_data,
   output logic       TxD,
   output logic       TxD_busy
);

   localparam int CPB = (CLKS_PER_BIT < 1) ? 1 : CLKS_PER_BIT;
   localparam int CW  = $clog2(CPB) + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [1:0]    r_state;
   logic [CW-1:0] r_baud;
   logic [2:0]    r_idx;
   logic [7:0]    r_shift;
   logic          r_txd;
   logic          r_busy;

   logic          w_tick;
   logic [2:0]    w_idx_nxt;

   assign w_tick    = (r_baud == CW'(CPB - 1));
   assign w_idx_nxt = r_idx + 3'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_baud  <= '0;
         r_idx   <= '0;
         r_shift <= '0;
         r_txd   <= 1'b1;
         r_busy  <= 1'b0;
      end else begin
         if (r_state != S_IDLE)
            r_baud <= w_tick ? '0 : r_baud + CW'(1);

         case (r_state)
            S_IDLE: begin
               r_txd  <= 1'b1;
               r_busy <= 1'b0;
               r_baud <= '0;
               if (TxD_start) begin
                  r_shift <= TxD_data;
                  r_idx   <= '0;
                  r_txd   <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_tick) begin
                  r_txd   <= r_shift[0];
                  r_idx   <= '0;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_tick) begin
                  if (r_idx == 3'd7) begin
                     r_txd   <= 1'b1;
                     r_state <= S_STOP;
                  end else begin
                     r_txd <= r_shift[w_idx_nxt];
                     r_idx <= w_idx_nxt;
                  end
               end
            end
            S_STOP: begin
               // End of stop bit is the first point a new byte may be taken; a held request goes straight out.
               if (w_tick) begin
                  if (TxD_start) begin
                     r_shift <= TxD_data;
                     r_idx   <= '0;
                     r_txd   <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= S_START;
                  end else begin
                     r_txd   <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign TxD      = r_txd;
   assign TxD_busy = r_busy;

endmodule

// File: tb/tb_uart_async_transmitter.sv
// Directed bench: one transmitter at one clock per bit, one at four clocks per bit, sampled on falling edges.
module tb_uart_async_transmitter;

   logic       clk;
   logic       rst_n;
   logic       start1;
   logic [7:0] data1;
   logic       txd1;
   logic       busy1;
   logic       start4;
   logic [7:0] data4;
   logic       txd4;
   logic       busy4;

   int n_tests;
   int n_fail;

   // Frames written in line order, first bit transmitted at index 9.
   localparam logic [9:0] FR_AB = 10'b0110101011;
   localparam logic [9:0] FR_FB = 10'b0110111111;
   localparam logic [9:0] FR_0F = 10'b0111100001;
   localparam logic [9:0] FR_3C = 10'b0001111001;

   uart_async_transmitter #(.CLKS_PER_BIT(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .TxD_start (start1),
      .TxD_data  (data1),
      .TxD       (txd1),
      .TxD_busy  (busy1)
   );

   uart_async_transmitter #(.CLKS_PER_BIT(4)) u_dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .TxD_start (start4),
      .TxD_data  (data4),
      .TxD       (txd4),
      .TxD_busy  (busy4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle1(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_txd"}, 32'(txd1), 32'd1);
         check({tag, "_busy"}, 32'(busy1), 32'd0);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      start1  = 1'b1;
      data1   = 8'hAB;
      start4  = 1'b1;
      data4   = 8'h00;

      // Reset held with start asserted: line stays idle
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_txd1", 32'(txd1), 32'd1);
         check("rst_busy1", 32'(busy1), 32'd0);
         check("rst_txd4", 32'(txd4), 32'd1);
         check("rst_busy4", 32'(busy4), 32'd0);
      end
      start1 = 1'b0;
      start4 = 1'b0;
      rst_n  = 1'b1;
      check_idle1("post_rst", 2);

      // Single byte 0xAB, one-cycle pulse
      start1 = 1'b1;
      data1  = 8'hAB;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) start1 = 1'b0;
         check("ab_txd", 32'(txd1), 32'(FR_AB[9-i]));
         check("ab_busy", 32'(busy1), 32'd1);
      end
      check_idle1("ab_end", 3);

      // Start held: 0xFB presented mid-frame only goes out after 0xAB, with no gap
      start1 = 1'b1;
      data1  = 8'hAB;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) data1 = 8'hFB;
         if (i == 10) start1 = 1'b0;
         check("hold_txd", 32'(txd1), (i < 10) ? 32'(FR_AB[9-i]) : 32'(FR_FB[19-i]));
         check("hold_busy", 32'(busy1), 32'd1);
      end
      check_idle1("hold_end", 3);

      // Request while busy is dropped
      start1 = 1'b1;
      data1  = 8'h0F;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) start1 = 1'b0;
         if (i == 3) begin
            start1 = 1'b1;
            data1  = 8'h55;
         end
         if (i == 4) start1 = 1'b0;
         check("ign_txd", 32'(txd1), 32'(FR_0F[9-i]));
         check("ign_busy", 32'(busy1), 32'd1);
      end
      check_idle1("ign_end", 12);

      // Reset during data bit 2 aborts at once; next frame is whole
      start1 = 1'b1;
      data1  = 8'hAB;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i == 0) start1 = 1'b0;
         check("abort_txd", 32'(txd1), 32'(FR_AB[9-i]));
      end
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_rst_txd", 32'(txd1), 32'd1);
      check("abort_rst_busy", 32'(busy1), 32'd0);
      rst_n = 1'b1;
      check_idle1("abort_idle", 2);
      start1 = 1'b1;
      data1  = 8'h3C;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) start1 = 1'b0;
         check("rec_txd", 32'(txd1), 32'(FR_3C[9-i]));
         check("rec_busy", 32'(busy1), 32'd1);
      end
      check_idle1("rec_end", 2);

      // Four clocks per bit, byte 0x00: 36 low, 4 high, 40 busy
      start4 = 1'b1;
      data4  = 8'h00;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 0) start4 = 1'b0;
         check("cpb4_txd", 32'(txd4), (i < 36) ? 32'd0 : 32'd1);
         check("cpb4_busy", 32'(busy4), 32'd1);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("cpb4_end_txd", 32'(txd4), 32'd1);
         check("cpb4_end_busy", 32'(busy4), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
